// File: rtl/sdram_pkg.sv
// Shared definitions for the sdram_model device responder: command
// encodings, burst FSM states, error codes and mode-register decode helpers.
// Optional build macro: SDRAM_TIMING_CHK_EN (adds the timing parameters).
package sdram_pkg;

  // {ras_n,cas_n,we_n} with cs_n=0; a deselected bus maps onto CMD_NOP
  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_AREF  = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_BST   = 4'b0110,
    CMD_NOP   = 4'b0111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WBURST,
    ST_RBURST
  } burst_st_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN  = 3'd1;
  localparam logic [2:0] ERR_AREF_OPEN = 3'd2;
  localparam logic [2:0] ERR_BANK_IDLE = 3'd3;
  localparam logic [2:0] ERR_NO_MODE   = 3'd4;
  localparam logic [2:0] ERR_MRS_BAD   = 3'd5;
  localparam logic [2:0] ERR_TIMING    = 3'd6;

  // Mode register CL field values that are accepted
  localparam logic [2:0] CL_2 = 3'd2;
  localparam logic [2:0] CL_3 = 3'd3;

`ifdef SDRAM_TIMING_CHK_EN
  localparam int unsigned TRCD = 2;
  localparam int unsigned TRP  = 2;
  localparam int unsigned TRFC = 7;
  localparam int unsigned TMRD = 2;
`endif

  function automatic cmd_e decode_cmd(input logic cs_n, input logic [2:0] rcw);
    return cs_n ? CMD_NOP : cmd_e'({1'b0, rcw});
  endfunction

  // Index of the last word in a burst for BL code 0..3 (BL = 1,2,4,8)
  function automatic logic [2:0] bl_last_idx(input logic [1:0] code);
    logic [3:0] words;
    words = 4'd1 << code;
    return 3'(words - 4'd1);
  endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// Per-bank state for sdram_model: open flag, open row and, when
// SDRAM_TIMING_CHK_EN is defined, the tRCD / tRP spacing counters.
module sdram_model_bank
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_BITS = 12
) (
  input  logic                sclk,
  input  logic                s_rst,
  input  logic                cke,
  input  logic                act,
  input  logic                pre,
  input  logic [ROW_BITS-1:0] row,
  output logic                is_open,
  output logic [ROW_BITS-1:0] open_row,
  output logic                rcd_busy,
  output logic                rp_busy
);

  // Open/close tracking; a precharge wins over a same-cycle activate
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      is_open  <= 1'b0;
      open_row <= '0;
    end else if (cke) begin
      if (pre) begin
        is_open <= 1'b0;
      end else if (act) begin
        is_open  <= 1'b1;
        open_row <= row;
      end
    end
  end

`ifdef SDRAM_TIMING_CHK_EN
  logic [2:0] rcd_cnt;
  logic [2:0] rp_cnt;

  // Down-counters loaded at the command; non-zero means the window is still open
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rcd_cnt <= '0;
      rp_cnt  <= '0;
    end else if (cke) begin
      if (act) rcd_cnt <= 3'(TRCD - 1);
      else if (rcd_cnt != '0) rcd_cnt <= rcd_cnt - 3'd1;
      if (pre) rp_cnt <= 3'(TRP - 1);
      else if (rp_cnt != '0) rp_cnt <= rp_cnt - 3'd1;
    end
  end

  assign rcd_busy = (rcd_cnt != '0);
  assign rp_busy  = (rp_cnt != '0);
`else
  assign rcd_busy = 1'b0;
  assign rp_busy  = 1'b0;
`endif

endmodule

// File: rtl/sdram_model.sv
// SDR SDRAM device responder: command decode, mode register, burst FSM,
// CAS-latency read pipeline, reduced-depth data array and error latch.
// Optional build macro: SDRAM_TIMING_CHK_EN (tRCD/tRP/tRFC/tMRD checks).
module sdram_model
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_BITS     = 12,
  parameter int unsigned COL_BITS     = 8,
  parameter int unsigned MEM_ROW_BITS = 4,
  parameter int unsigned DATA_W       = 16
) (
  input  logic                  sclk,
  input  logic                  s_rst,
  input  logic                  cke,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [1:0]            ba,
  input  logic [ROW_BITS-1:0]   addr,
  input  logic [DATA_W/8-1:0]   dqm,
  input  logic [DATA_W-1:0]     dq_i,
  output logic [DATA_W-1:0]     dq_o,
  output logic                  dq_oe,
  output logic                  mode_set,
  output logic                  err,
  output logic [2:0]            err_code
);

  localparam int unsigned AW = 2 + MEM_ROW_BITS + COL_BITS;
  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:(1 << AW) - 1];

  cmd_e                cmd;
  burst_st_e           st, st_nx;
  logic [1:0]          bl_code;
  logic                cl3;
  logic [3:0]          bank_open, act_vec, pre_vec, rcd_busy, rp_busy;
  logic [ROW_BITS-1:0] bank_row [4];

  logic [1:0]              b_bank;
  logic [MEM_ROW_BITS-1:0] b_row;
  logic [COL_BITS-1:0]     b_col;
  logic [2:0]              b_idx, b_last;
  logic                    b_ap;

  logic           mode_miss, exec, is_rw, rw_ok, trunc, step, tim_viol, glob_busy;
  logic           wr_en, rd_issue;
  logic [AW-1:0]  acc_a;
  logic [2:0]     code;
  logic [1:0]     pipe_v;
  logic [AW-1:0]  pipe_a [2];
  logic           unused_row_hi;

  // Column within the BL-aligned block, wrapping at the block boundary
  function automatic logic [COL_BITS-1:0] col_of(input logic [COL_BITS-1:0] start,
                                                 input logic [2:0] k,
                                                 input logic [2:0] last);
    logic [COL_BITS-1:0] mask;
    mask = COL_BITS'(last);
    return (start & ~mask) | ((start + COL_BITS'(k)) & mask);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_bank
    sdram_model_bank #(.ROW_BITS(ROW_BITS)) u_bank (
      .sclk     (sclk),
      .s_rst    (s_rst),
      .cke      (cke),
      .act      (act_vec[g]),
      .pre      (pre_vec[g]),
      .row      (addr),
      .is_open  (bank_open[g]),
      .open_row (bank_row[g]),
      .rcd_busy (rcd_busy[g]),
      .rp_busy  (rp_busy[g])
    );
  end

  // Upper row bits alias onto the stored rows and are intentionally dropped
  assign unused_row_hi = ^{bank_row[0][ROW_BITS-1:MEM_ROW_BITS], bank_row[1][ROW_BITS-1:MEM_ROW_BITS],
                           bank_row[2][ROW_BITS-1:MEM_ROW_BITS], bank_row[3][ROW_BITS-1:MEM_ROW_BITS]};

`ifdef SDRAM_TIMING_CHK_EN
  logic [2:0] rfc_cnt, mrd_cnt;

  // Device-wide spacing after AREF and MRS
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rfc_cnt <= '0;
      mrd_cnt <= '0;
    end else if (cke) begin
      if (exec && cmd == CMD_AREF) rfc_cnt <= 3'(TRFC - 1);
      else if (rfc_cnt != '0) rfc_cnt <= rfc_cnt - 3'd1;
      if (exec && cmd == CMD_MRS) mrd_cnt <= 3'(TMRD - 1);
      else if (mrd_cnt != '0) mrd_cnt <= mrd_cnt - 3'd1;
    end
  end

  assign glob_busy = (rfc_cnt != '0) || (mrd_cnt != '0);
`else
  assign glob_busy = 1'b0;
`endif

  // Command decode, error classification, bank control and burst next-state
  always_comb begin
    cmd       = decode_cmd(cs_n, {ras_n, cas_n, we_n});
    st_nx     = st;
    code      = ERR_NONE;
    act_vec   = '0;
    pre_vec   = '0;
    wr_en     = 1'b0;
    rd_issue  = 1'b0;
    acc_a     = '0;
    is_rw     = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    mode_miss = cke && !mode_set &&
                (is_rw || cmd == CMD_ACT || cmd == CMD_BST);
    exec      = cke && !mode_miss;
    rw_ok     = exec && is_rw && bank_open[ba];
    tim_viol  = (glob_busy && cmd != CMD_NOP) || (is_rw && rcd_busy[ba]) ||
                (cmd == CMD_ACT && rp_busy[ba]);
    trunc     = (st != ST_IDLE) && exec &&
                (is_rw || cmd == CMD_BST || (cmd == CMD_PRE && (addr[10] || ba == b_bank)));
    step      = cke && (st != ST_IDLE) && !trunc;

    if (mode_miss) begin
      code = ERR_NO_MODE;
    end else if (exec && tim_viol) begin
      code = ERR_TIMING;
    end else if (exec) begin
      case (cmd)
        CMD_ACT:             if (bank_open[ba]) code = ERR_ACT_OPEN;
        CMD_READ, CMD_WRITE: if (!bank_open[ba]) code = ERR_BANK_IDLE;
        CMD_AREF:            if (|bank_open) code = ERR_AREF_OPEN;
        CMD_MRS:             if (addr[2] || !(addr[6:4] == CL_2 || addr[6:4] == CL_3))
                               code = ERR_MRS_BAD;
        default: ;
      endcase
    end

    for (int unsigned i = 0; i < 4; i++) begin
      act_vec[i] = exec && cmd == CMD_ACT && !bank_open[ba] && ba == 2'(i);
      pre_vec[i] = exec && cmd == CMD_PRE && (addr[10] || ba == 2'(i));
    end

    if (step) begin
      acc_a    = {b_bank, b_row, col_of(b_col, b_idx, b_last)};
      wr_en    = (st == ST_WBURST);
      rd_issue = (st == ST_RBURST);
      if (b_idx == b_last) begin
        st_nx = ST_IDLE;
        if (b_ap) pre_vec[b_bank] = 1'b1;
      end
    end else if (trunc) begin
      st_nx = ST_IDLE;
    end

    // Word 0 of a new burst is handled at the command edge itself; a BL=1
    // burst therefore never leaves IDLE and auto-precharges immediately
    if (rw_ok) begin
      acc_a    = {ba, bank_row[ba][MEM_ROW_BITS-1:0], addr[COL_BITS-1:0]};
      wr_en    = (cmd == CMD_WRITE);
      rd_issue = (cmd == CMD_READ);
      if (bl_code != 2'd0) begin
        st_nx = (cmd == CMD_WRITE) ? ST_WBURST : ST_RBURST;
      end else begin
        st_nx = ST_IDLE;
        if (addr[10]) pre_vec[ba] = 1'b1;
      end
    end
  end

  // Burst FSM state register
  always_ff @(posedge sclk) begin
    if (s_rst) st <= ST_IDLE;
    else       st <= st_nx;
  end

  // Burst context captured at READ/WRITE, word index advanced per beat
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      b_bank <= '0;
      b_row  <= '0;
      b_col  <= '0;
      b_idx  <= '0;
      b_last <= '0;
      b_ap   <= 1'b0;
    end else if (rw_ok) begin
      b_bank <= ba;
      b_row  <= bank_row[ba][MEM_ROW_BITS-1:0];
      b_col  <= addr[COL_BITS-1:0];
      b_idx  <= 3'd1;
      b_last <= bl_last_idx(bl_code);
      b_ap   <= addr[10];
    end else if (step) begin
      b_idx <= b_idx + 3'd1;
    end
  end

  // Mode register; each field only updates when its value is legal
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      mode_set <= 1'b0;
      bl_code  <= 2'd0;
      cl3      <= 1'b1;
    end else if (exec && cmd == CMD_MRS) begin
      mode_set <= 1'b1;
      if (!addr[2]) bl_code <= addr[1:0];
      if (addr[6:4] == CL_2)      cl3 <= 1'b0;
      else if (addr[6:4] == CL_3) cl3 <= 1'b1;
    end
  end

  // Sticky error flag keeping the first code seen
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (code != ERR_NONE && !err) begin
      err      <= 1'b1;
      err_code <= code;
    end
  end

  // Byte-masked array write; contents survive reset
  always_ff @(posedge sclk) begin
    if (!s_rst && wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (!dqm[i]) mem[acc_a][i*8 +: 8] <= dq_i[i*8 +: 8];
      end
    end
  end

  // CAS-latency pipeline: read issued at edge N appears after edge N+CL-1
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      pipe_v    <= '0;
      pipe_a[0] <= '0;
      pipe_a[1] <= '0;
      dq_oe     <= 1'b0;
      dq_o      <= '0;
    end else if (cke) begin
      pipe_v    <= {pipe_v[0], rd_issue};
      pipe_a[0] <= acc_a;
      pipe_a[1] <= pipe_a[0];
      if (cl3) begin
        dq_oe <= pipe_v[1];
        if (pipe_v[1]) dq_o <= mem[pipe_a[1]];
      end else begin
        dq_oe <= pipe_v[0];
        if (pipe_v[0]) dq_o <= mem[pipe_a[0]];
      end
    end
  end

endmodule

// File: tb/tb_sdram_model.sv
// Directed + randomized bench for sdram_model with a word-addressed
// reference memory and bench-side tracking of open rows and mode.
module tb_sdram_model;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000, BST = 4'b0110;

  logic        sclk = 1'b0;
  logic        s_rst, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [11:0] addr;
  logic [1:0]  dqm;
  logic [15:0] dq_i, dq_o;
  logic        dq_oe, mode_set, err;
  logic [2:0]  err_code;

  int total = 0;
  int bad   = 0;

  logic [15:0] mm [int];
  logic [15:0] wd [8];
  logic [1:0]  wm [8];
  logic [11:0] orow [4];
  bit          oopen [4];
  int          cur_bl, cur_cl;

  always #5 sclk = ~sclk;

  sdram_model #(.ROW_BITS(12), .COL_BITS(8), .MEM_ROW_BITS(4), .DATA_W(16)) dut (
    .sclk(sclk), .s_rst(s_rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .dqm(dqm), .dq_i(dq_i), .dq_o(dq_o),
    .dq_oe(dq_oe), .mode_set(mode_set), .err(err), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input int b, input logic [11:0] a,
                      input logic [15:0] d, input logic [1:0] m);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = 2'(b); addr = a; dq_i = d; dqm = m;
    @(posedge sclk);
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) step(NOP, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    nop(2);
    s_rst = 1'b0;
    for (int i = 0; i < 4; i++) oopen[i] = 0;
    cur_bl = 1; cur_cl = 3;
  endtask

  function automatic int key(input int b, input logic [11:0] row, input int col);
    return b * 4096 + (int'(row) % 16) * 256 + col;
  endfunction

  function automatic int wcol(input int start, input int k);
    return (start / cur_bl) * cur_bl + (start % cur_bl + k) % cur_bl;
  endfunction

  task automatic mrs(input int bl, input int cl);
    logic [11:0] a;
    a = 12'(cl) << 4;
    case (bl)
      2: a[1:0] = 2'd1;
      4: a[1:0] = 2'd2;
      8: a[1:0] = 2'd3;
      default: a[1:0] = 2'd0;
    endcase
    step(MRS, 0, a, '0, '0);
    cur_bl = bl; cur_cl = cl;
    nop(1);
  endtask

  task automatic activate(input int b, input logic [11:0] row);
    step(ACT, b, row, '0, '0);
    oopen[b] = 1; orow[b] = row;
    nop(1);
  endtask

  // Writes nwords words of wd/wm; fewer than BL words ends with BURST STOP
  task automatic do_write(input int b, input int col, input bit ap, input int nwords);
    int kk;
    logic [15:0] old;
    for (int k = 0; k < nwords; k++) begin
      if (k == 0) step(WR, b, 12'(col) | (ap ? 12'h400 : 12'h000), wd[k], wm[k]);
      else        step(NOP, 0, '0, wd[k], wm[k]);
      kk  = key(b, orow[b], wcol(col, k));
      old = mm.exists(kk) ? mm[kk] : 16'hxxxx;
      mm[kk] = {wm[k][1] ? old[15:8] : wd[k][15:8], wm[k][0] ? old[7:0] : wd[k][7:0]};
    end
    if (nwords < cur_bl) step(BST, 0, '0, '0, '0);
    else if (ap) oopen[b] = 0;
    nop(1);
  endtask

  task automatic do_read(input int b, input int col, input bit ap, input string tag);
    logic [15:0] exp [8];
    bit want;
    for (int k = 0; k < cur_bl; k++) exp[k] = mm[key(b, orow[b], wcol(col, k))];
    step(RD, b, 12'(col) | (ap ? 12'h400 : 12'h000), '0, '0);
    for (int j = 0; j <= cur_cl + cur_bl; j++) begin
      if (j > 0) nop(1);
      want = (j >= cur_cl - 1) && (j < cur_cl - 1 + cur_bl);
      chk({tag, "_oe"}, 32'(dq_oe), 32'(want));
      if (want) chk({tag, "_dq"}, 32'(dq_o), 32'(exp[j - cur_cl + 1]));
    end
    if (ap) oopen[b] = 0;
  endtask

  initial begin
    int b, bl, base, st;
    logic [11:0] row;
    cke = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = NOP;
    ba = '0; addr = '0; dqm = '0; dq_i = '0;
    do_reset();
    chk("rst_dq_oe", 32'(dq_oe), 0);
    chk("rst_dq_o", 32'(dq_o), 0);
    chk("rst_mode_set", 32'(mode_set), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);

    // READ before any MRS
    step(RD, 0, '0, '0, '0);
    for (int j = 0; j < 6; j++) begin
      chk("nomode_oe", 32'(dq_oe), 0);
      nop(1);
    end
    chk("nomode_err", 32'(err), 1);
    chk("nomode_code", 32'(err_code), 4);

    // CL=3 BL=4 basic write/read
    do_reset();
    step(MRS, 0, 12'h032, '0, '0);
    cur_bl = 4; cur_cl = 3;
    nop(1);
    chk("mrs_mode_set", 32'(mode_set), 1);
    chk("mrs_err", 32'(err), 0);
    activate(1, 12'd5);
    for (int k = 0; k < 4; k++) begin wd[k] = 16'(k + 1); wm[k] = 2'b00; end
    do_write(1, 0, 0, 4);
    do_read(1, 0, 0, "bl4");

    // CL=2 BL=8 wrapped burst from col 6
    mrs(8, 2);
    for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'b00; end
    do_write(1, 6, 0, 8);
    do_read(1, 6, 0, "wrap8");

    // Byte mask over an existing word
    mrs(1, 3);
    wd[0] = 16'h1122; wm[0] = 2'b00;
    do_write(1, 20, 0, 1);
    wd[0] = 16'hAABB; wm[0] = 2'b10;
    do_write(1, 20, 0, 1);
    do_read(1, 20, 0, "dqm");

    // Burst stop after 3 words, then auto-precharge read, then re-open aliased row
    mrs(8, 3);
    for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'b00; end
    do_write(1, 32, 0, 8);
    for (int k = 0; k < 8; k++) wd[k] = 16'($urandom);
    do_write(1, 32, 0, 3);
    do_read(1, 32, 1, "bst_ap");
    activate(1, 12'h215);
    chk("ap_reopen_err", 32'(err), 0);
    do_read(1, 32, 0, "alias");
    step(ACT, 1, 12'd7, '0, '0);
    nop(1);
    chk("act_open_err", 32'(err), 1);
    chk("act_open_code", 32'(err_code), 1);

    // Illegal burst length in MRS
    do_reset();
    step(MRS, 0, 12'h034, '0, '0);
    nop(1);
    chk("mrs_bad_code", 32'(err_code), 5);
    chk("mrs_bad_mode_set", 32'(mode_set), 1);

    // AREF with an open bank
    do_reset();
    mrs(1, 3);
    activate(2, 12'd3);
    step(REF, 0, '0, '0, '0);
    nop(1);
    chk("aref_open_code", 32'(err_code), 2);

    // READ to an idle bank
    do_reset();
    mrs(1, 3);
    step(RD, 3, '0, '0, '0);
    for (int j = 0; j < 5; j++) begin
      chk("idle_rd_oe", 32'(dq_oe), 0);
      nop(1);
    end
    chk("idle_rd_code", 32'(err_code), 3);

`ifdef SDRAM_TIMING_CHK_EN
    do_reset();
    mrs(1, 3);
    step(ACT, 0, 12'd1, '0, '0);
    step(RD, 0, '0, '0, '0);
    nop(1);
    chk("trcd_code", 32'(err_code), 6);
`endif

    // Randomized bursts across banks, rows, BL and CL
    do_reset();
    mrs(1, 3);
    for (int it = 0; it < 16; it++) begin
      b   = int'($urandom_range(0, 3));
      row = 12'($urandom);
      bl  = 1 << $urandom_range(0, 3);
      mrs(bl, int'($urandom_range(2, 3)));
      if (oopen[b]) begin
        step(PRE, b, '0, '0, '0);
        oopen[b] = 0;
        nop(1);
      end
      activate(b, row);
      base = (int'($urandom_range(0, 255)) / bl) * bl;
      for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'b00; end
      do_write(b, base, 0, bl);
      for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'($urandom); end
      st = base + int'($urandom_range(0, bl - 1));
      do_write(b, st, 0, bl);
      st = base + int'($urandom_range(0, bl - 1));
      do_read(b, st, bit'($urandom_range(0, 1)), "rand");
    end
    chk("rand_err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
